// File: rtl/jk_bank_ctrl_if.sv
// Command handshake between a command source and jk_bank_ctrl.
interface jk_bank_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_data;
    logic [WIDTH-1:0] req_mask;

    modport master (
        output req_valid,
        output req_op,
        output req_data,
        output req_mask,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_op,
        input  req_data,
        input  req_mask,
        output req_ready
    );
endinterface

// File: rtl/jk_bank_ctrl.sv
// jk_bank_ctrl: sequences LOAD/SET/CLEAR/TOGGLE commands onto a bank of JK
// flip-flops, driving J/K for exactly one clock per command.
// Build option: JK_CTRL_VERIFY_EN adds a CHECK state that compares the bank
// against the expected value and reports err with done. Without it, done
// follows the APPLY cycle and err is tied low.
module jk_bank_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    jk_bank_ctrl_if.slave    req,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

`ifdef JK_CTRL_VERIFY_EN
    typedef enum logic [1:0] {IDLE, APPLY, CHECK} state_t;
`else
    typedef enum logic [1:0] {IDLE, APPLY} state_t;
`endif

    state_t           state;
    state_t           state_d;
    logic [WIDTH-1:0] j_d;
    logic [WIDTH-1:0] k_d;
    logic             done_d;
    logic             busy_d;
    logic             ready_q;
    logic             ready_d;
    logic [WIDTH-1:0] exc_j_c;
    logic [WIDTH-1:0] exc_k_c;

`ifdef JK_CTRL_VERIFY_EN
    logic [WIDTH-1:0] expect_q;
    logic [WIDTH-1:0] expect_d;
    logic [WIDTH-1:0] expect_c;
    logic             err_d;
`endif

    // Ready is withheld while rst is high so a command is never seen as taken.
    assign req.req_ready = ready_q & ~rst;

    // Per-bit excitation (and expected result) from the live command and bank.
    always_comb begin
        exc_j_c = '0;
        exc_k_c = '0;
`ifdef JK_CTRL_VERIFY_EN
        expect_c = q_in;
`endif
        unique case (req.req_op)
            OP_LOAD: begin
                exc_j_c = req.req_mask &  req.req_data & ~q_in;
                exc_k_c = req.req_mask & ~req.req_data &  q_in;
`ifdef JK_CTRL_VERIFY_EN
                expect_c = (q_in & ~req.req_mask) | (req.req_data & req.req_mask);
`endif
            end
            OP_SET: begin
                exc_j_c = req.req_mask;
`ifdef JK_CTRL_VERIFY_EN
                expect_c = q_in | req.req_mask;
`endif
            end
            OP_CLEAR: begin
                exc_k_c = req.req_mask;
`ifdef JK_CTRL_VERIFY_EN
                expect_c = q_in & ~req.req_mask;
`endif
            end
            OP_TOGGLE: begin
                exc_j_c = req.req_mask;
                exc_k_c = req.req_mask;
`ifdef JK_CTRL_VERIFY_EN
                expect_c = q_in ^ req.req_mask;
`endif
            end
            default: begin
                exc_j_c = '0;
                exc_k_c = '0;
            end
        endcase
    end

    // Next-state and next-output logic; J/K default to zero so they last one cycle.
    always_comb begin
        state_d = state;
        j_d     = '0;
        k_d     = '0;
        done_d  = 1'b0;
        busy_d  = busy;
        ready_d = ready_q;
`ifdef JK_CTRL_VERIFY_EN
        err_d    = 1'b0;
        expect_d = expect_q;
`endif
        unique case (state)
            IDLE: begin
                if (req.req_valid) begin
                    state_d = APPLY;
                    j_d     = exc_j_c;
                    k_d     = exc_k_c;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
`ifdef JK_CTRL_VERIFY_EN
                    expect_d = expect_c;
`endif
                end
            end
            APPLY: begin
`ifdef JK_CTRL_VERIFY_EN
                state_d = CHECK;
`else
                state_d = IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                ready_d = 1'b1;
`endif
            end
`ifdef JK_CTRL_VERIFY_EN
            CHECK: begin
                state_d = IDLE;
                done_d  = 1'b1;
                err_d   = (q_in != expect_q);
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
`endif
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            j_out   <= '0;
            k_out   <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
            ready_q <= 1'b1;
`ifdef JK_CTRL_VERIFY_EN
            err      <= 1'b0;
            expect_q <= '0;
`endif
        end else begin
            state   <= state_d;
            j_out   <= j_d;
            k_out   <= k_d;
            done    <= done_d;
            busy    <= busy_d;
            ready_q <= ready_d;
`ifdef JK_CTRL_VERIFY_EN
            err      <= err_d;
            expect_q <= expect_d;
`endif
        end
    end

`ifndef JK_CTRL_VERIFY_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Scoreboard bench for jk_bank_ctrl driving a behavioural 8-bit JK bank.
module tb_jk_bank_ctrl;

    localparam int unsigned WIDTH = 8;
`ifdef JK_CTRL_VERIFY_EN
    localparam int DLY    = 3;
    localparam bit VERIFY = 1'b1;
`else
    localparam int DLY    = 2;
    localparam bit VERIFY = 1'b0;
`endif

    localparam logic [1:0] LOAD   = 2'b00;
    localparam logic [1:0] SET    = 2'b01;
    localparam logic [1:0] CLEAR  = 2'b10;
    localparam logic [1:0] TOGGLE = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] q_bank = 8'h00;
    logic [7:0] j_out;
    logic [7:0] k_out;
    logic       busy;
    logic       done;
    logic       err;
    bit         fault = 1'b0;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;

    logic [15:0] exp_x[$];
    logic [8:0]  exp_d[$];
    int          acc_q[$];

    jk_bank_ctrl_if #(.WIDTH(WIDTH)) bus();

    jk_bank_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (bus),
        .q_in  (q_bank),
        .j_out (j_out),
        .k_out (k_out),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // JK bank model; fault makes bit 3 ignore its excitation.
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (!(fault && i == 3)) begin
                case ({j_out[i], k_out[i]})
                    2'b10:   q_bank[i] <= 1'b1;
                    2'b01:   q_bank[i] <= 1'b0;
                    2'b11:   q_bank[i] <= ~q_bank[i];
                    default: q_bank[i] <= q_bank[i];
                endcase
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    endtask

    // Monitor: pops expectations whenever the DUT presents excitation or done.
    initial begin
        bit prev_exc;
        prev_exc = 1'b0;
        forever begin
            @(negedge clk);
            if ((j_out | k_out) != 8'h00) begin
                chk("exc_single_cycle", 32'(prev_exc), 32'd0);
                chk("busy_in_apply", 32'(busy), 32'd1);
                if (exp_x.size() == 0) chk("exc_unexpected", {16'h0, j_out, k_out}, 32'd0);
                else chk("excitation_jk", {16'h0, j_out, k_out}, {16'h0, exp_x.pop_front()});
                prev_exc = 1'b1;
            end else begin
                prev_exc = 1'b0;
            end
            if (done === 1'b1) begin
                if (exp_d.size() == 0) chk("done_unexpected", 32'(done), 32'd0);
                else chk("done_err_q", {23'h0, err, q_bank}, {23'h0, exp_d.pop_front()});
                if (acc_q.size() == 0) chk("done_no_accept", 32'd1, 32'd0);
                else chk("done_latency", 32'(cyc - acc_q.pop_front()), 32'(DLY));
            end
            if (bus.req_valid && bus.req_ready) acc_q.push_back(cyc);
            if (rst) acc_q.delete();
        end
    end

    // Present a command, queue its expectations, wait for acceptance.
    task automatic issue(input logic [1:0] op, input logic [7:0] d, input logic [7:0] m,
                         input logic [7:0] xj, input logic [7:0] xk,
                         input logic xerr, input logic [7:0] xq,
                         input bit expect_done, input bit keep, output int acc);
        bit ok;
        ok = 1'b0;
        acc = 0;
        bus.req_op    = op;
        bus.req_data  = d;
        bus.req_mask  = m;
        bus.req_valid = 1'b1;
        if ((xj | xk) != 8'h00) exp_x.push_back({xj, xk});
        if (expect_done) exp_d.push_back({xerr, xq});
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                ok = 1'b1;
                acc = cyc;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (!keep) bus.req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (exp_x.size() == 0 && exp_d.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a0, a1, a2, ax;
        bus.req_valid = 1'b0;
        bus.req_op    = LOAD;
        bus.req_data  = 8'h00;
        bus.req_mask  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_j_out", 32'(j_out), 32'd0);
        chk("rst_k_out", 32'(k_out), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;

        // Basic ops from 0x00
        issue(LOAD,   8'hA5, 8'hFF, 8'hA5, 8'h00, 1'b0, 8'hA5, 1'b1, 1'b0, ax);
        issue(TOGGLE, 8'h00, 8'h0F, 8'h0F, 8'h0F, 1'b0, 8'hAA, 1'b1, 1'b0, ax);
        issue(TOGGLE, 8'h00, 8'h0F, 8'h0F, 8'h0F, 1'b0, 8'hA5, 1'b1, 1'b0, ax);
        issue(SET,    8'h00, 8'h50, 8'h50, 8'h00, 1'b0, 8'hF5, 1'b1, 1'b0, ax);
        issue(CLEAR,  8'h00, 8'h05, 8'h00, 8'h05, 1'b0, 8'hF0, 1'b1, 1'b0, ax);
        // Zero mask: no excitation, still completes
        issue(LOAD,   8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'hF0, 1'b1, 1'b0, ax);
        issue(CLEAR,  8'h00, 8'hFF, 8'h00, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0, ax);
        wait_drain();

        // Bank bit 3 stuck during a LOAD 0xFF
        fault = 1'b1;
        issue(LOAD,   8'hFF, 8'hFF, 8'hFF, 8'h00, VERIFY, 8'hF7, 1'b1, 1'b0, ax);
        wait_drain();
        fault = 1'b0;

        // req_valid held high across back-to-back commands
        issue(TOGGLE, 8'h00, 8'h01, 8'h01, 8'h01, 1'b0, 8'hF6, 1'b1, 1'b1, a0);
        issue(TOGGLE, 8'h00, 8'h01, 8'h01, 8'h01, 1'b0, 8'hF7, 1'b1, 1'b1, a1);
        issue(TOGGLE, 8'h00, 8'h01, 8'h01, 8'h01, 1'b0, 8'hF6, 1'b1, 1'b0, a2);
        chk("held_gap_1", 32'(a1 - a0), 32'(DLY));
        chk("held_gap_2", 32'(a2 - a1), 32'(DLY));
        wait_drain();

        // Reset during APPLY: bank still updates, no done
        issue(TOGGLE, 8'h00, 8'hFF, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, ax);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("apply_rst_j", 32'(j_out), 32'd0);
        chk("apply_rst_k", 32'(k_out), 32'd0);
        chk("apply_rst_busy", 32'(busy), 32'd0);
        chk("apply_rst_done", 32'(done), 32'd0);
        chk("apply_rst_bank", 32'(q_bank), 32'h09);
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(LOAD,   8'h3C, 8'hFF, 8'h34, 8'h01, 1'b0, 8'h3C, 1'b1, 1'b0, ax);
        wait_drain();
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("end_exp_x_empty", 32'(exp_x.size()), 32'd0);
        chk("end_exp_d_empty", 32'(exp_d.size()), 32'd0);
        chk("end_idle_busy", 32'(busy), 32'd0);
        chk("end_idle_ready", 32'(bus.req_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
